// File: rtl/fd_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// fd_hazard_ctrl_if
// Bundles the signals exchanged between the WISC pipeline datapath and the
// hazard/stall controller.
//   Decode side   : rsD, rtD, rsValidD, rtValidD, haltD
//   Execute side  : regDstE, memReadE, branchTakenE
//   Memory stalls : imemStallF, dmemStallM
//   Controls out  : pcWriteEn, fdWriteEn, fdFlush, dxWriteEn, dxBubble,
//                   xmWriteEn, mwWriteEn, halted
//   Debug counters: stallCount, flushCount
// Modports: master = pipeline datapath, slave = hazard controller.
// ---------------------------------------------------------------------------
interface fd_hazard_ctrl_if;
  logic [2:0]  rsD;
  logic [2:0]  rtD;
  logic        rsValidD;
  logic        rtValidD;
  logic        haltD;
  logic [2:0]  regDstE;
  logic        memReadE;
  logic        branchTakenE;
  logic        imemStallF;
  logic        dmemStallM;

  logic        pcWriteEn;
  logic        fdWriteEn;
  logic        fdFlush;
  logic        dxWriteEn;
  logic        dxBubble;
  logic        xmWriteEn;
  logic        mwWriteEn;
  logic        halted;
  logic [15:0] stallCount;
  logic [15:0] flushCount;

  modport master (
    output rsD, rtD, rsValidD, rtValidD, haltD,
    output regDstE, memReadE, branchTakenE, imemStallF, dmemStallM,
    input  pcWriteEn, fdWriteEn, fdFlush, dxWriteEn, dxBubble,
    input  xmWriteEn, mwWriteEn, halted, stallCount, flushCount
  );

  modport slave (
    input  rsD, rtD, rsValidD, rtValidD, haltD,
    input  regDstE, memReadE, branchTakenE, imemStallF, dmemStallM,
    output pcWriteEn, fdWriteEn, fdFlush, dxWriteEn, dxBubble,
    output xmWriteEn, mwWriteEn, halted, stallCount, flushCount
  );
endinterface

// File: rtl/fd_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// fd_hazard_ctrl
// Hazard and stall controller for the five-stage WISC pipeline. Drives the
// PC / F-D / D-X write enables plus flush and bubble controls, handling
// load-use hazards, taken-branch redirects, instruction/data memory stalls
// and HALT. Also keeps saturating stall and flush event counters.
// Ports:
//   clk : system clock
//   rst : synchronous, active-high reset
//   hz  : fd_hazard_ctrl_if.slave (pipeline inputs, controls, counters)
// All controls are combinational from state and current inputs.
// ---------------------------------------------------------------------------
module fd_hazard_ctrl (
  input logic             clk,
  input logic             rst,
  fd_hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    IMEM_WAIT = 2'd1,
    DMEM_WAIT = 2'd2,
    HALT      = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] stall_count_q, stall_count_d;
  logic [15:0] flush_count_q, flush_count_d;

  logic load_use;
  logic pc_we, fd_we, fd_flush, dx_we, dx_bubble, xm_we, mw_we, halted;
  logic stall_inc, flush_inc;

  // Forwarding covers everything else, so only a load feeding the very next
  // instruction needs a stall.
  assign load_use = hz.memReadE &
                    ((hz.rsValidD & (hz.rsD == hz.regDstE)) |
                     (hz.rtValidD & (hz.rtD == hz.regDstE)));

  // Priority table. The wait states produce the same controls as RUN; they
  // only record why the front end is stalled.
  always_comb begin
    pc_we     = 1'b1;
    fd_we     = 1'b1;
    fd_flush  = 1'b0;
    dx_we     = 1'b1;
    dx_bubble = 1'b0;
    xm_we     = 1'b1;
    mw_we     = 1'b1;
    halted    = 1'b0;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    state_d   = RUN;

    if (rst) begin
      pc_we     = 1'b0;
      fd_we     = 1'b0;
      fd_flush  = 1'b1;
      dx_we     = 1'b0;
      dx_bubble = 1'b1;
      xm_we     = 1'b0;
      mw_we     = 1'b0;
    end else if (state_q == HALT) begin
      // Front end stays stopped; the back end drains behind bubbles unless
      // data memory is holding it.
      state_d   = HALT;
      halted    = 1'b1;
      pc_we     = 1'b0;
      fd_we     = 1'b0;
      dx_bubble = 1'b1;
      if (hz.dmemStallM) begin
        dx_we     = 1'b0;
        dx_bubble = 1'b0;
        xm_we     = 1'b0;
        mw_we     = 1'b0;
      end
    end else if (hz.dmemStallM) begin
      // Freeze everything; a taken branch in E is re-presented afterwards.
      pc_we     = 1'b0;
      fd_we     = 1'b0;
      dx_we     = 1'b0;
      xm_we     = 1'b0;
      mw_we     = 1'b0;
      stall_inc = 1'b1;
      state_d   = DMEM_WAIT;
    end else if (hz.branchTakenE) begin
      fd_flush  = 1'b1;
      dx_bubble = 1'b1;
      flush_inc = 1'b1;
    end else if (load_use) begin
      pc_we     = 1'b0;
      fd_we     = 1'b0;
      dx_bubble = 1'b1;
      stall_inc = 1'b1;
    end else if (hz.haltD) begin
      // HALT itself moves on into execute; the haltD cycle is not a stall.
      pc_we     = 1'b0;
      fd_we     = 1'b0;
      state_d   = HALT;
    end else if (hz.imemStallF) begin
      pc_we     = 1'b0;
      fd_flush  = 1'b1;
      stall_inc = 1'b1;
      state_d   = IMEM_WAIT;
    end

    stall_count_d = stall_count_q;
    if (stall_inc && (stall_count_q != 16'hFFFF)) begin
      stall_count_d = stall_count_q + 16'd1;
    end
    flush_count_d = flush_count_q;
    if (flush_inc && (flush_count_q != 16'hFFFF)) begin
      flush_count_d = flush_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      stall_count_q <= 16'd0;
      flush_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign hz.pcWriteEn  = pc_we;
  assign hz.fdWriteEn  = fd_we;
  assign hz.fdFlush    = fd_flush;
  assign hz.dxWriteEn  = dx_we;
  assign hz.dxBubble   = dx_bubble;
  assign hz.xmWriteEn  = xm_we;
  assign hz.mwWriteEn  = mw_we;
  assign hz.halted     = halted;
  assign hz.stallCount = stall_count_q;
  assign hz.flushCount = flush_count_q;

endmodule
